gj_stream_scheduler: RTL and testbench

//  Packet-granular round-robin scheduler that shares the gap-junction core's single
//  AXI-Stream input (input_r_*_0) between two packet sources (s0, s1).
//  - Counts completed packets and stops after MAX_PACKETS.
//  - Sits between the stimulus/neuron-state generators and the HLS gap-junction IP.

---
 rtl/gj_stream_scheduler.sv | 148 ++++++++++++++
 tb/tb_gj_stream_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gj_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gj_stream_scheduler
// Brief    : Packet-granular round-robin arbiter sharing the gap-junction
//            core's single AXI-Stream input between two packet sources.
// Revision : 1.0 - initial release
// ============================================================================
module gj_stream_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PACKETS = 20000,
    parameter int CNT_WIDTH   = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,

    input  logic [DATA_WIDTH-1:0] s0_TDATA,
    input  logic                  s0_TVALID,
    input  logic                  s0_TLAST,
    output logic                  s0_TREADY,

    input  logic [DATA_WIDTH-1:0] s1_TDATA,
    input  logic                  s1_TVALID,
    input  logic                  s1_TLAST,
    output logic                  s1_TREADY,

    output logic [DATA_WIDTH-1:0] input_r_TDATA_0,
    output logic                  input_r_TVALID_0,
    output logic                  input_r_TLAST_0,
    input  logic                  input_r_TREADY_0,

    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  packet_count,
    output logic                  done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_max_count = CNT_WIDTH'(MAX_PACKETS);
    localparam logic [CNT_WIDTH-1:0] c_count_sat = '1;
    localparam logic [CNT_WIDTH-1:0] c_count_one = CNT_WIDTH'(1);
    localparam bit                   c_limited   = (MAX_PACKETS != 0);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [1:0]           r_grant;
    logic [1:0]           w_grant_nxt;
    logic                 r_rr_ptr;
    logic                 w_rr_ptr_nxt;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] w_count_inc;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_pkt_end;

    // Zero-latency datapath: the registered grant alone steers the mux.
    always_comb begin
        input_r_TDATA_0  = '0;
        input_r_TVALID_0 = 1'b0;
        input_r_TLAST_0  = 1'b0;
        s0_TREADY        = 1'b0;
        s1_TREADY        = 1'b0;
        if (r_grant[0]) begin
            input_r_TDATA_0  = s0_TDATA;
            input_r_TVALID_0 = s0_TVALID;
            input_r_TLAST_0  = s0_TLAST;
            s0_TREADY        = input_r_TREADY_0;
        end else if (r_grant[1]) begin
            input_r_TDATA_0  = s1_TDATA;
            input_r_TVALID_0 = s1_TVALID;
            input_r_TLAST_0  = s1_TLAST;
            s1_TREADY        = input_r_TREADY_0;
        end
    end

    assign w_pkt_end   = input_r_TVALID_0 & input_r_TREADY_0 & input_r_TLAST_0;
    assign w_count_inc = (r_count == c_count_sat) ? r_count : r_count + c_count_one;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_count_nxt  = r_count;
        w_done_nxt   = r_done;
        case (r_state)
            c_st_idle: begin
                w_grant_nxt = 2'b00;
                if (enable && !r_done && (s0_TVALID || s1_TVALID)) begin
                    w_state_nxt = c_st_busy;
                    if (s0_TVALID && s1_TVALID) begin
                        w_grant_nxt = r_rr_ptr ? 2'b10 : 2'b01;
                    end else if (s0_TVALID) begin
                        w_grant_nxt = 2'b01;
                    end else begin
                        w_grant_nxt = 2'b10;
                    end
                end
            end
            c_st_busy: begin
                if (w_pkt_end) begin
                    w_count_nxt  = w_count_inc;
                    // Favour the source that did not just finish.
                    w_rr_ptr_nxt = r_grant[0];
                    w_grant_nxt  = 2'b00;
                    if (c_limited && (w_count_inc == c_max_count)) begin
                        w_state_nxt = c_st_done;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_done: begin
                w_grant_nxt = 2'b00;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_grant  <= 2'b00;
            r_rr_ptr <= 1'b0;
            r_count  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_count  <= w_count_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign grant        = r_grant;
    assign packet_count = r_count;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gj_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gj_stream_scheduler
// Brief    : Randomized self-checking bench for gj_stream_scheduler against a
//            cycle-level reference model plus packet-level delivery totals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gj_stream_scheduler;

    localparam int DW   = 32;
    localparam int MAXP = 3;
    localparam int CW   = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] sd [2];
    logic          sv [2];
    logic          sl [2];
    logic [DW-1:0] s0_TDATA, s1_TDATA;
    logic          s0_TVALID, s0_TLAST, s0_TREADY;
    logic          s1_TVALID, s1_TLAST, s1_TREADY;
    logic [DW-1:0] input_r_TDATA_0;
    logic          input_r_TVALID_0, input_r_TLAST_0, input_r_TREADY_0;
    logic [1:0]    grant;
    logic [CW-1:0] packet_count;
    logic          done;

    assign s0_TDATA  = sd[0];
    assign s0_TVALID = sv[0];
    assign s0_TLAST  = sl[0];
    assign s1_TDATA  = sd[1];
    assign s1_TVALID = sv[1];
    assign s1_TLAST  = sl[1];

    always #5 clk = ~clk;

    gj_stream_scheduler #(
        .DATA_WIDTH (DW),
        .MAX_PACKETS(MAXP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .s0_TDATA        (s0_TDATA),
        .s0_TVALID       (s0_TVALID),
        .s0_TLAST        (s0_TLAST),
        .s0_TREADY       (s0_TREADY),
        .s1_TDATA        (s1_TDATA),
        .s1_TVALID       (s1_TVALID),
        .s1_TLAST        (s1_TLAST),
        .s1_TREADY       (s1_TREADY),
        .input_r_TDATA_0 (input_r_TDATA_0),
        .input_r_TVALID_0(input_r_TVALID_0),
        .input_r_TLAST_0 (input_r_TLAST_0),
        .input_r_TREADY_0(input_r_TREADY_0),
        .grant           (grant),
        .packet_count    (packet_count),
        .done            (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Source packet generators: packet = len words base, base+1, ...
    int            len [2];
    int            beat [2];
    logic [31:0]   base [2];
    bit            vld [2];
    int            delivered [2];
    int            p_valid [2];
    int            p_ready;
    int            p_enable;
    bit            ready_toggle;
    bit            tog;

    // Reference model: owner 0 = none, 1 = s0, 2 = s1
    int            m_owner;
    bit            m_ptr;
    int            m_count;
    bit            m_done;

    task automatic new_packet(input int i);
        len[i]  = $urandom_range(5, 1);
        beat[i] = 0;
        base[i] = (32'(i) << 28) | ($urandom & 32'h0FFF_FFF0);
        vld[i]  = 1'b0;
    endtask

    task automatic cycle(input bit rst_in);
        logic [31:0] e_data;
        logic        e_valid, e_last;
        logic [1:0]  e_rdy, e_grant;
        reset            = rst_in;
        enable           = ($urandom_range(99) < p_enable);
        tog              = ~tog;
        input_r_TREADY_0 = ready_toggle ? tog : ($urandom_range(99) < p_ready);
        for (int i = 0; i < 2; i++) begin
            if (!vld[i]) vld[i] = ($urandom_range(99) < p_valid[i]);
            sv[i] = vld[i];
            sd[i] = vld[i] ? base[i] + 32'(beat[i]) : $urandom;
            sl[i] = vld[i] ? (beat[i] == len[i] - 1) : 1'($urandom_range(1));
        end
        #1;
        e_grant = 2'b00; e_data = '0; e_valid = 1'b0; e_last = 1'b0; e_rdy = 2'b00;
        if (m_owner != 0) begin
            e_grant                = (m_owner == 1) ? 2'b01 : 2'b10;
            e_data                 = sd[m_owner-1];
            e_valid                = sv[m_owner-1];
            e_last                 = sl[m_owner-1];
            e_rdy[m_owner-1]       = input_r_TREADY_0;
        end
        check("grant",  32'(grant), 32'(e_grant));
        check("tdata",  input_r_TDATA_0, e_data);
        check("tvalid", 32'(input_r_TVALID_0), 32'(e_valid));
        check("tlast",  32'(input_r_TLAST_0), 32'(e_last));
        check("sready", 32'({s1_TREADY, s0_TREADY}), 32'(e_rdy));
        check("count",  32'(packet_count), 32'(m_count));
        check("done",   32'(done), 32'(m_done));

        // Model advance for the coming edge
        if (rst_in) begin
            m_owner = 0; m_ptr = 1'b0; m_count = 0; m_done = 1'b0;
        end else if (!m_done) begin
            if (m_owner == 0) begin
                if (enable && (sv[0] || sv[1]))
                    m_owner = (sv[0] && sv[1]) ? (m_ptr ? 2 : 1) : (sv[0] ? 1 : 2);
            end else if (e_valid && input_r_TREADY_0 && e_last) begin
                m_ptr   = (m_owner == 1);
                m_owner = 0;
                if (m_count < (1 << CW) - 1) m_count++;
                if (m_count == MAXP) m_done = 1'b1;
            end
        end

        // Sources react to the ready they actually see
        for (int i = 0; i < 2; i++) begin
            if (sv[i] && (i == 0 ? s0_TREADY : s1_TREADY)) begin
                if (beat[i] == len[i] - 1) begin
                    delivered[i]++;
                    new_packet(i);
                end else begin
                    beat[i]++;
                    vld[i] = 1'b0;
                end
            end
        end
        if (rst_in) begin
            for (int i = 0; i < 2; i++) begin
                new_packet(i);
                delivered[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tog = 1'b0; ready_toggle = 1'b0;
        p_valid[0] = 100; p_valid[1] = 100; p_ready = 100; p_enable = 100;
        for (int i = 0; i < 2; i++) begin
            new_packet(i);
            delivered[i] = 0;
            sd[i] = '0; sv[i] = 1'b0; sl[i] = 1'b0;
        end
        m_owner = 0; m_ptr = 1'b0; m_count = 0; m_done = 1'b0;
        reset = 1'b1; enable = 1'b0; input_r_TREADY_0 = 1'b0;
        @(posedge clk);
        #1;

        // Held reset with both sources offering data
        repeat (20) cycle(1'b1);

        // Directed single 4-beat packet from s0
        p_valid[1] = 0;
        len[0] = 4; beat[0] = 0; base[0] = 32'h10; vld[0] = 1'b0;
        repeat (6) cycle(1'b0);
        check("t2_count", 32'(packet_count), 32'd1);
        check("t2_deliv", 32'(delivered[0]), 32'd1);

        // Randomized phases, each starting from reset
        for (int ph = 0; ph < 40; ph++) begin
            cycle(1'b1);
            p_valid[0]   = (ph % 4 == 0) ? 100 : $urandom_range(100, 10);
            p_valid[1]   = (ph % 4 == 0) ? 100 : $urandom_range(100, 0);
            p_ready      = (ph % 4 == 0) ? 100 : $urandom_range(100, 30);
            p_enable     = (ph % 5 == 4) ? $urandom_range(100, 40) : 100;
            ready_toggle = (ph % 4 == 1);
            for (int c = 0; c < 60; c++) cycle($urandom_range(79) == 0);
            check("pkts", 32'(packet_count), 32'(delivered[0] + delivered[1]));
        end
        ready_toggle = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
